pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Game-sequencing controller for the 64x64 Pong LED-matrix renderer. Owns all game state: ball position and direction, paddle positions with clamping, scores, and serve/point/game-over sequencing. Outputs are registered and drive the renderer's ball, paddle-top and score inputs directly. One update per game tick; the tick is derived from the system clock.

Parameters:
TICK_DIV, 1_000_000, system clocks per game tick (minimum 2)
SERVE_TICKS, 32, ticks the ball is held at centre before a serve
WIN_SCORE, 7, score that ends the game (maximum 7, the highest displayable digit)
PAD_MIN, 5, lowest legal paddle top row (keeps paddles clear of score rows 0-4)
PAD_MAX, 58, highest legal paddle top row (paddle spans top..top+5)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begins or restarts a game from IDLE or GAME_OVER
p1_up, p1_dn  in  1 each  player-1 paddle controls (up decrements y)
p2_up, p2_dn  in  1 each  player-2 paddle controls
bx, by  out  6 each  ball column, row
p1y, p2y  out  6 each  paddle top row
sc1, sc2  out  3 each  scores
state  out  3  current FSM state encoding (pkg enum)
winner  out  2  0 = none, 1 = P1, 2 = P2
tick  out  1  one-clock pulse marking each game-tick update

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: bx=31, by=34, p1y=p2y=31, sc1=sc2=0, state=IDLE, winner=0, tick=0, dx=right, dy=down, tick counter=0, serve counter=0.
- Tick generator: counts 0..TICK_DIV-1 and pulses tick when the count is TICK_DIV-1. All game updates occur on the clock edge where tick=1, and outputs change on that same edge. No other state changes, except FSM transitions on start.
- Paddles, on every tick in any state except IDLE and GAME_OVER:
  - up-only: y-1; dn-only: y+1; both or neither: hold.
  - Result saturates to [PAD_MIN, PAD_MAX], so no wrap-around.
- FSM states: IDLE, SERVE, PLAY, POINT, GAME_OVER.
  - IDLE: start=1 -> SERVE; clear scores and winner; ball to (31,34); dx=right.
  - SERVE: ball held at (31,34). The serve counter increments per tick. At SERVE_TICKS-1 -> PLAY and the counter clears. dy keeps its prior value.
  - PLAY, per tick, vertical motion:
    - dy=down and by=63: by=62, dy=up.
    - dy=up and by=PAD_MIN: by=PAD_MIN+1, dy=down.
    - else by±1.
  - PLAY, per tick, horizontal motion:
    - dx=left and bx=2: if p1y<=by<=p1y+5, then bx=3, dx=right; else -> POINT, scorer=P2, ball held.
    - dx=right and bx=61: if p2y<=by<=p2y+5, then bx=60, dx=left; else -> POINT, scorer=P1.
    - else bx±1.
  - Collision test uses the pre-tick by and pre-tick paddle registers. Paddle and ball update on the same tick.
  - Corner case: vertical and horizontal reflections on the same tick both apply.
  - POINT: one clock, not tick-gated. Increment the scorer's score.
    - If the new score equals WIN_SCORE: set winner -> GAME_OVER.
    - Else ball to (31,34), dx toward the player who conceded -> SERVE.
  - GAME_OVER: ball and scores frozen. start=1 -> SERVE with scores cleared and winner=0.
  - start is ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE. Score arithmetic is 3-bit and cannot overflow given WIN_SCORE<=7.
- Reset asserted mid-game: all registers return to reset values immediately, independent of clk.

Decomposition:
- pong_pkg holds:
  - state enum (IDLE, SERVE, PLAY, POINT, GAME_OVER)
  - field constants: FIELD_W=64, FIELD_H=64, P1X=0, P2X=62, HIT_L=2, HIT_R=61, CENTRE_X=31, CENTRE_Y=34, PAD_LEN=6
  - direction typedefs
- One sub-module, pong_tick_gen, contains the TICK_DIV counter and tick pulse.

Test Plan:
- Reset and serve: TICK_DIV=4, SERVE_TICKS=2; release rst_n, hold start=1 for 1 clock -> state=SERVE. After 2 ticks state=PLAY, and the first PLAY tick gives bx=32, by=35.
- Paddle clamp: p1_up held 40 ticks from p1y=31 -> p1y reaches 5 and stays 5. p1_up and p1_dn held together -> p1y unchanged.
- Paddle hit: force ball to bx=3, by=33, dx=left, dy=down, p1y=30 -> next tick bx=2. On the following tick by=34 is within 30..35, so bx=3, dx=right, and sc2 stays 0.
- Miss and score: same setup with p1y=50 -> at bx=2 the next tick gives POINT, then sc2=1, ball=(31,34), dx=left, state=SERVE.
- Wall and corner: ball at by=63, dy=down, bx=61, dx=right, p2y=58 -> by=62, dy=up, bx=60, dx=left on one tick.
- Game over and async reset: WIN_SCORE=2, two P1 points -> winner=1, state=GAME_OVER, scores frozen across 10 ticks. start -> scores 0. Pulse rst_n low mid-PLAY, between clock edges -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, state encodings and small helpers for the Pong game controller.
package pong_pkg;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SERVE     = 3'd1;
   localparam logic [2:0] PLAY      = 3'd2;
   localparam logic [2:0] POINT     = 3'd3;
   localparam logic [2:0] GAME_OVER = 3'd4;

   localparam int FIELD_W  = 64;
   localparam int FIELD_H  = 64;
   localparam int P1X      = 0;
   localparam int P2X      = 62;
   localparam int HIT_L    = 2;
   localparam int HIT_R    = 61;
   localparam int CENTRE_X = 31;
   localparam int CENTRE_Y = 34;
   localparam int PAD_LEN  = 6;

   typedef logic dir_t;
   localparam dir_t DX_RIGHT = 1'b0;
   localparam dir_t DX_LEFT  = 1'b1;
   localparam dir_t DY_DOWN  = 1'b0;
   localparam dir_t DY_UP    = 1'b1;

   typedef logic [1:0] player_t;
   localparam player_t WIN_NONE = 2'd0;
   localparam player_t WIN_P1   = 2'd1;
   localparam player_t WIN_P2   = 2'd2;

   // One paddle step, saturating at the legal rows; opposing buttons cancel.
   function automatic logic [5:0] pad_step(input logic [5:0] y, input logic up, input logic dn,
                                           input logic [5:0] lo, input logic [5:0] hi);
      logic [5:0] r;
      r = y;
      if (up && !dn)
         r = (y <= lo) ? lo : y - 6'd1;
      else if (dn && !up)
         r = (y >= hi) ? hi : y + 6'd1;
      return r;
   endfunction

   function automatic logic in_pad(input logic [5:0] ball_y, input logic [5:0] pad_y);
      return (ball_y >= pad_y) && ({1'b0, ball_y} <= {1'b0, pad_y} + 7'(PAD_LEN - 1));
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player controls in, renderer-facing game state out.
interface pong_game_ctrl_if;
   logic       start;
   logic       p1_up;
   logic       p1_dn;
   logic       p2_up;
   logic       p2_dn;
   logic [5:0] bx;
   logic [5:0] by;
   logic [5:0] p1y;
   logic [5:0] p2y;
   logic [2:0] sc1;
   logic [2:0] sc2;
   logic [2:0] state;
   logic [1:0] winner;
   logic       tick;

   modport master (
      output start, p1_up, p1_dn, p2_up, p2_dn,
      input  bx, by, p1y, p2y, sc1, sc2, state, winner, tick
   );

   modport slave (
      input  start, p1_up, p1_dn, p2_up, p2_dn,
      output bx, by, p1y, p2y, sc1, sc2, state, winner, tick
   );
endinterface

// File: rtl/pong_tick_gen.sv
// Divides the system clock down to the game tick: a one-clock pulse every TICK_DIV clocks.
module pong_tick_gen #(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, paddle clamping, scoring and serve/point/game-over flow.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = 1_000_000,
   parameter int SERVE_TICKS = 32,
   parameter int WIN_SCORE   = 7,
   parameter int PAD_MIN     = 5,
   parameter int PAD_MAX     = 58
) (
   input logic             clk,
   input logic             rst_n,
   pong_game_ctrl_if.slave io
);

   localparam int SW = $clog2(SERVE_TICKS + 1);
   localparam logic [SW-1:0] SRV_LAST = SW'(SERVE_TICKS - 1);
   localparam logic [5:0] PMIN   = 6'(PAD_MIN);
   localparam logic [5:0] PMAX   = 6'(PAD_MAX);
   localparam logic [5:0] CX     = 6'(CENTRE_X);
   localparam logic [5:0] CY     = 6'(CENTRE_Y);
   localparam logic [5:0] XL     = 6'(HIT_L);
   localparam logic [5:0] XR     = 6'(HIT_R);
   localparam logic [5:0] BOTTOM = 6'(FIELD_H - 1);
   localparam logic [2:0] WIN    = 3'(WIN_SCORE);

   logic          tick;
   logic [2:0]    st;
   logic [5:0]    bx_q, by_q, p1y_q, p2y_q;
   logic [2:0]    sc1_q, sc2_q;
   player_t       win_q, scorer;
   dir_t          dx, dy;
   logic [SW-1:0] srv_cnt;

   logic [5:0]    nbx, nby;
   dir_t          ndx, ndy;
   logic          miss;
   player_t       miss_scorer;
   logic [2:0]    nsc;

   pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Candidate ball move for this tick; paddle hits use the pre-tick row and paddles.
   always_comb begin
      nby         = by_q;
      ndy         = dy;
      nbx         = bx_q;
      ndx         = dx;
      miss        = 1'b0;
      miss_scorer = WIN_NONE;
      if (dy == DY_DOWN) begin
         if (by_q == BOTTOM) begin
            nby = BOTTOM - 6'd1;
            ndy = DY_UP;
         end else begin
            nby = by_q + 6'd1;
         end
      end else begin
         if (by_q == PMIN) begin
            nby = PMIN + 6'd1;
            ndy = DY_DOWN;
         end else begin
            nby = by_q - 6'd1;
         end
      end
      if (dx == DX_LEFT) begin
         if (bx_q == XL) begin
            if (in_pad(by_q, p1y_q)) begin
               nbx = XL + 6'd1;
               ndx = DX_RIGHT;
            end else begin
               miss        = 1'b1;
               miss_scorer = WIN_P2;
            end
         end else begin
            nbx = bx_q - 6'd1;
         end
      end else begin
         if (bx_q == XR) begin
            if (in_pad(by_q, p2y_q)) begin
               nbx = XR - 6'd1;
               ndx = DX_LEFT;
            end else begin
               miss        = 1'b1;
               miss_scorer = WIN_P1;
            end
         end else begin
            nbx = bx_q + 6'd1;
         end
      end
      nsc = ((scorer == WIN_P2) ? sc2_q : sc1_q) + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         bx_q    <= CX;
         by_q    <= CY;
         p1y_q   <= 6'd31;
         p2y_q   <= 6'd31;
         sc1_q   <= '0;
         sc2_q   <= '0;
         win_q   <= WIN_NONE;
         scorer  <= WIN_NONE;
         dx      <= DX_RIGHT;
         dy      <= DY_DOWN;
         srv_cnt <= '0;
      end else begin
         if (tick && st != IDLE && st != GAME_OVER) begin
            p1y_q <= pad_step(p1y_q, io.p1_up, io.p1_dn, PMIN, PMAX);
            p2y_q <= pad_step(p2y_q, io.p2_up, io.p2_dn, PMIN, PMAX);
         end
         case (st)
            IDLE, GAME_OVER: begin
               if (io.start) begin
                  st      <= SERVE;
                  sc1_q   <= '0;
                  sc2_q   <= '0;
                  win_q   <= WIN_NONE;
                  bx_q    <= CX;
                  by_q    <= CY;
                  dx      <= DX_RIGHT;
                  srv_cnt <= '0;
               end
            end
            SERVE: begin
               if (tick) begin
                  if (srv_cnt == SRV_LAST) begin
                     srv_cnt <= '0;
                     st      <= PLAY;
                  end else begin
                     srv_cnt <= srv_cnt + SW'(1);
                  end
               end
            end
            PLAY: begin
               if (tick) begin
                  if (miss) begin
                     st     <= POINT;
                     scorer <= miss_scorer;
                  end else begin
                     bx_q <= nbx;
                     by_q <= nby;
                     dx   <= ndx;
                     dy   <= ndy;
                  end
               end
            end
            POINT: begin
               if (scorer == WIN_P2)
                  sc2_q <= nsc;
               else
                  sc1_q <= nsc;
               if (nsc == WIN) begin
                  win_q <= scorer;
                  st    <= GAME_OVER;
               end else begin
                  bx_q <= CX;
                  by_q <= CY;
                  dx   <= (scorer == WIN_P2) ? DX_LEFT : DX_RIGHT;
                  st   <= SERVE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign io.bx     = bx_q;
   assign io.by     = by_q;
   assign io.p1y    = p1y_q;
   assign io.p2y    = p2y_q;
   assign io.sc1    = sc1_q;
   assign io.sc2    = sc2_q;
   assign io.state  = st;
   assign io.winner = win_q;
   assign io.tick   = tick;

endmodule
